mont_exp_host: RTL and testbench

- Initiator for the mont_exp start/done handshake.
- Assembles 192-bit operands x (base) and y (exponent) from a 32-bit word stream and drives them into mont_exp.
- Asserts start, waits for done, captures z, then streams z back out as 32-bit words.
- Acts as the bus-side front end of the RSA datapath, so upstream logic never handles 192-bit buses.

---
 rtl/mont_pkg.sv | 24 ++
 rtl/mont_word_shift.sv | 59 +++++
 rtl/mont_exp_host.sv | 202 ++++++++++++++++++++
 tb/tb_mont_exp_host.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mont_pkg
// Description : Shared widths, derived counts and FSM state encoding for the
//               mont_exp host front end.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_pkg;

    localparam int W_OP    = 192;                // operand / result width
    localparam int W_BUS   = 32;                 // stream word width
    localparam int N_WORDS = W_OP / W_BUS;       // words per operand
    localparam int IDX_W   = $clog2(N_WORDS);    // word index width
    localparam int CNT_W   = $clog2(2 * N_WORDS);// stream word counter width

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mont_word_shift.sv
`default_nettype none
// ============================================================================
// Module      : mont_word_shift
// Description : Wide register with a word-indexed write port, a full-width
//               capture port and a word-indexed read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_word_shift
    import mont_pkg::*;
#(
    parameter int WIDTH = W_OP,
    parameter int WORD  = W_BUS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [$clog2(WIDTH/WORD)-1:0]   wr_idx,
    input  logic [WORD-1:0]                 wr_data,
    input  logic                            cap_en,
    input  logic [WIDTH-1:0]                cap_data,
    input  logic [$clog2(WIDTH/WORD)-1:0]   rd_idx,
    output logic [WIDTH-1:0]                q,
    output logic [WORD-1:0]                 rd_data
);

    localparam int NW   = WIDTH / WORD;
    localparam int IW   = $clog2(NW);

    logic [WIDTH-1:0] r_q;

    // Full-width capture wins over a single-word write; both hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (cap_en) begin
            r_q <= cap_data;
        end else if (wr_en) begin
            for (int i = 0; i < NW; i++) begin
                if (wr_idx == IW'(i)) begin
                    r_q[i*WORD +: WORD] <= wr_data;
                end
            end
        end
    end

    // Word select for the read side; indices past the last word read zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NW; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_data = r_q[i*WORD +: WORD];
            end
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mont_exp_host.sv
`default_nettype none
// ============================================================================
// Module      : mont_exp_host
// Description : Stream-to-wide front end for mont_exp. Packs x and y from
//               32-bit words, runs the start/done handshake, then streams z
//               back out least-significant word first.
//               Optional macro MONT_EXP_HOST_TIMEOUT_EN adds a done timeout
//               that aborts the operation and raises err.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_exp_host
    import mont_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65535
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_BUS-1:0] in_data,
    output logic [W_OP-1:0]  exp_x,
    output logic [W_OP-1:0]  exp_y,
    output logic             exp_start,
    input  logic             exp_done,
    input  logic [W_OP-1:0]  exp_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_BUS-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_start;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_load_last;
    logic               w_drain_last;
    logic               w_is_y;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_capture;
    logic               w_timeout;
    logic [W_BUS-1:0]   w_z_word;
    logic [W_BUS-1:0]   w_x_rd;
    logic [W_BUS-1:0]   w_y_rd;
    logic [W_OP-1:0]    w_z_q;
    logic               w_unused_sink;

    assign w_in_fire    = in_valid && r_in_ready;
    assign w_out_fire   = (r_state == DRAIN) && out_ready;
    assign w_load_last  = (r_cnt == CNT_W'(2 * N_WORDS - 1));
    assign w_drain_last = (r_cnt == CNT_W'(N_WORDS - 1));
    assign w_is_y       = (r_cnt >= CNT_W'(N_WORDS));
    assign w_wr_idx     = IDX_W'(w_is_y ? (r_cnt - CNT_W'(N_WORDS)) : r_cnt);
    assign w_rd_idx     = IDX_W'(r_cnt);
    assign w_capture    = (r_state == WAIT) && exp_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the outputs that follow the current state.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = !((r_state == LOAD) && (r_cnt == '0));
        case (r_state)
            LOAD:  if (w_in_fire && w_load_last) w_next = ISSUE;
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (exp_done)       w_next = DRAIN;
                else if (w_timeout) w_next = LOAD;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_drain_last;
                out_data  = w_z_word;
                if (w_out_fire && w_drain_last) w_next = LOAD;
            end
            default: w_next = LOAD;
        endcase
    end

    // in_ready and exp_start are registered from the next state so they are
    // glitch-free and in_ready stays low for the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_in_ready <= (w_next == LOAD);
            r_start    <= (w_next == ISSUE) || (w_next == WAIT);
        end
    end

    // Shared word counter: input word index in LOAD, output word index in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_in_fire) begin
            r_cnt <= w_load_last ? '0 : r_cnt + CNT_W'(1);
        end else if (w_out_fire) begin
            r_cnt <= w_drain_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    mont_word_shift #(.WIDTH(W_OP), .WORD(W_BUS)) u_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_in_fire && !w_is_y),
        .wr_idx   (w_wr_idx),
        .wr_data  (in_data),
        .cap_en   (1'b0),
        .cap_data ('0),
        .rd_idx   (w_rd_idx),
        .q        (exp_x),
        .rd_data  (w_x_rd)
    );

    mont_word_shift #(.WIDTH(W_OP), .WORD(W_BUS)) u_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_in_fire && w_is_y),
        .wr_idx   (w_wr_idx),
        .wr_data  (in_data),
        .cap_en   (1'b0),
        .cap_data ('0),
        .rd_idx   (w_rd_idx),
        .q        (exp_y),
        .rd_data  (w_y_rd)
    );

    mont_word_shift #(.WIDTH(W_OP), .WORD(W_BUS)) u_z (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_data  ('0),
        .cap_en   (w_capture),
        .cap_data (exp_z),
        .rd_idx   (w_rd_idx),
        .q        (w_z_q),
        .rd_data  (w_z_word)
    );

    // Ports of the shared register block that this instance set does not use.
    assign w_unused_sink = ^{w_x_rd, w_y_rd, w_z_q};

`ifdef MONT_EXP_HOST_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_tcnt;
    logic        r_err;

    // Wait-cycle counter: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (r_state == ISSUE) begin
            r_tcnt <= '0;
        end else if (r_state == WAIT) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == WAIT) && !exp_done && (r_tcnt == c_tmo_last);

    // Sticky timeout flag, cleared by the next accepted input word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (w_in_fire) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign exp_start = r_start;

endmodule
`default_nettype wire

// File: tb/tb_mont_exp_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_mont_exp_host
// Description : Scoreboard bench for mont_exp_host with a mont_exp stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_exp_host;
    import mont_pkg::*;

    localparam int LAT = 40;
    localparam int TMO = 100;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W_BUS-1:0] in_data;
    logic [W_OP-1:0]  exp_x;
    logic [W_OP-1:0]  exp_y;
    logic             exp_start;
    logic             exp_done;
    logic [W_OP-1:0]  exp_z;
    logic             out_valid;
    logic             out_ready;
    logic [W_BUS-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             err;

    mont_exp_host #(.TIMEOUT_CYC(TMO)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .exp_x     (exp_x),
        .exp_y     (exp_y),
        .exp_start (exp_start),
        .exp_done  (exp_done),
        .exp_z     (exp_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W_OP-1:0] q_x[$];
    logic [W_OP-1:0] q_y[$];
    logic [32:0]     q_out[$];
    int              q_start[$];

    bit       done_en = 1'b1;
    bit       bp_mode = 1'b0;
    bit [3:0] bp_pat  = 4'b1001;

    task automatic chk(input string name, input logic [192:0] act, input logic [192:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // mont_exp stub: done pulses LAT cycles after start rises.
    initial begin
        int scnt;
        scnt     = 0;
        exp_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_start && done_en) begin
                if (scnt == LAT) exp_done = 1'b1;
                scnt++;
            end else begin
                scnt     = 0;
                exp_done = 1'b0;
            end
        end
    end

    // Downstream ready: always on, or 1,0,0,1 repeating in backpressure mode.
    initial begin
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode) begin
                out_ready = bp_pat[k % 4];
                k++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Output monitor: stall stability and scoreboard pop on each accepted word.
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) chk("stall_hold", {out_last, out_data}, {hold_l, hold_d});
            hold_v = 1'b0;
            if (out_valid) begin
                if (!out_ready) begin
                    hold_v = 1'b1;
                    hold_d = out_data;
                    hold_l = out_last;
                end else if (q_out.size() > 0) begin
                    chk("out_word", {out_last, out_data}, q_out.pop_front());
                end else begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %h, expected no word", out_data);
                end
            end
        end
    end

    // Issue monitor: operands at the start edge and length of the start pulse.
    logic prev_start = 1'b0;
    int   start_cnt  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
            start_cnt  = 0;
        end else begin
            if (exp_start && !prev_start) begin
                if (q_x.size() > 0) begin
                    chk("issue_x", exp_x, q_x.pop_front());
                    chk("issue_y", exp_y, q_y.pop_front());
                end else begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got start, expected none");
                end
            end
            if (exp_start) begin
                start_cnt++;
            end else if (start_cnt != 0) begin
                if (q_start.size() > 0) chk("start_len", start_cnt, q_start.pop_front());
                start_cnt = 0;
            end
            prev_start = exp_start;
        end
    end

    task automatic send_word(input logic [31:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_bound", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [191:0] x, input logic [191:0] y, input int maxgap);
        logic [31:0] w;
        q_x.push_back(x);
        q_y.push_back(y);
        for (int i = 0; i < 2 * N_WORDS; i++) begin
            w = (i < N_WORDS) ? x[i*32 +: 32] : y[(i-N_WORDS)*32 +: 32];
            send_word(w, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
            if (i == 0) chk("err_after_word0", err, 1'b0);
        end
        chk("issue_timing", {exp_start, busy}, 2'b11);
    endtask

    task automatic push_z(input logic [191:0] z);
        for (int i = 0; i < N_WORDS; i++) q_out.push_back({(i == N_WORDS - 1), z[i*32 +: 32]});
    endtask

    task automatic wait_op(input bit stray);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        if (stray) begin
            in_valid = 1'b1;
            in_data  = 32'hBAD0BAD0;
        end
        while ((q_out.size() > 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
            if (stray && busy && in_ready) bad++;
        end
        in_valid = 1'b0;
        chk("op_complete_bound", {busy, 32'(q_out.size())}, 33'd0);
        if (stray) chk("stray_in_ready", bad, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        exp_z    = '0;
        #3;
        chk("reset_flags", {in_ready, exp_start, out_valid, out_last, busy, err}, 6'b0);
        chk("reset_x", exp_x, '0);
        chk("reset_y", exp_y, '0);
        chk("reset_out_data", out_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_at_release", in_ready, 1'b0);
        @(negedge clk);
        chk("in_ready_first_clock", in_ready, 1'b1);

        // Basic: 2^11 = 0x800.
        exp_z = 192'h800;
        q_start.push_back(LAT + 1);
        q_out.push_back({1'b0, 32'h00000800});
        q_out.push_back({1'b0, 32'h00000000});
        q_out.push_back({1'b0, 32'h00000000});
        q_out.push_back({1'b0, 32'h00000000});
        q_out.push_back({1'b0, 32'h00000000});
        q_out.push_back({1'b1, 32'h00000000});
        send_op(192'd2, 192'd11, 0);
        wait_op(1'b0);

        // Backpressure with a byte-ramp result.
        bp_mode = 1'b1;
        exp_z   = 192'h0102030405060708090a0b0c0d0e0f101112131415161718;
        q_start.push_back(LAT + 1);
        q_out.push_back({1'b0, 32'h15161718});
        q_out.push_back({1'b0, 32'h11121314});
        q_out.push_back({1'b0, 32'h0d0e0f10});
        q_out.push_back({1'b0, 32'h090a0b0c});
        q_out.push_back({1'b0, 32'h05060708});
        q_out.push_back({1'b1, 32'h01020304});
        send_op(192'd3, 192'd5, 0);
        wait_op(1'b0);
        bp_mode = 1'b0;

        // Input gaps of 0-5 cycles.
        exp_z = 192'hCAFEF00D_13579BDF_2468ACE0_FFFF0000_0000FFFF_80000001;
        q_start.push_back(LAT + 1);
        push_z(exp_z);
        send_op(192'hDEADBEEF_00112233_44556677_8899AABB_CCDDEEFF_01234567,
                192'hFEDCBA98_76543210_0F1E2D3C_4B5A6978_A5A5A5A5_5A5A5A5A, 5);
        wait_op(1'b0);

        // Stray in_valid during WAIT and DRAIN, then a clean follow-on load.
        exp_z = 192'h11111111_22222222_33333333_44444444_55555555_66666666;
        q_start.push_back(LAT + 1);
        push_z(exp_z);
        send_op(192'h7, 192'h9, 0);
        wait_op(1'b1);
        exp_z = 192'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3_E4E4E4E4_F5F5F5F5;
        q_start.push_back(LAT + 1);
        push_z(exp_z);
        send_op(192'h0123456789ABCDEF_0000000000000001_FEDCBA9876543210,
                192'h00000000_00000001_00000000_00000000_00000000_00010001, 0);
        wait_op(1'b0);

        // Reset ten cycles into WAIT.
        exp_z = 192'hFFFF;
        send_op(192'h55, 192'h66, 0);
        repeat (10) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {in_ready, exp_start, out_valid, out_last, busy, err}, 6'b0);
        chk("midrst_x", exp_x, '0);
        chk("midrst_y", exp_y, '0);
        chk("midrst_out_data", out_data, '0);
        q_out.delete();
        q_start.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_z = 192'h9ABCDEF0_12345678_0F0F0F0F_F0F0F0F0_00000003_C0000000;
        q_start.push_back(LAT + 1);
        push_z(exp_z);
        send_op(192'h42, 192'h24, 2);
        wait_op(1'b0);

`ifdef MONT_EXP_HOST_TIMEOUT_EN
        // Timeout: done never arrives.
        done_en = 1'b0;
        q_start.push_back(TMO + 1);
        send_op(192'h13, 192'h17, 0);
        begin
            int n;
            n = 0;
            while (busy && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("tmo_flags", {busy, exp_start, out_valid, err, in_ready}, 5'b00011);
        done_en = 1'b1;
        exp_z = 192'h5;
        q_start.push_back(LAT + 1);
        push_z(exp_z);
        send_op(192'h1, 192'h2, 0);
        wait_op(1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
